// File: rtl/player_life_manager.sv
// player_life_manager: tracks lives, BCD score, post-hit invulnerability/blink and game state.
module player_life_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4,
  parameter int ENEMY_POINTS  = 5,
  parameter int WALL_POINTS   = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        player_hit,
  input  logic        enemy_killed,
  input  logic        wall_destroyed,
  output logic [2:0]  lives,
  output logic [11:0] score_bcd,
  output logic        invulnerable,
  output logic        player_blink,
  output logic        game_active,
  output logic        game_over
);
  typedef enum logic [1:0] {IDLE, PLAY, INVULN, GAME_OVER} state_t;
  state_t state, state_n;
  logic [2:0]  lives_n;
  logic [11:0] score_n, score_sum;
  logic [7:0]  invuln_cnt, invuln_n;
  logic [3:0]  blink_cnt, blink_n;
  logic        blink_q_n;
  logic [4:0]  add, us, ts, hs;
  logic [1:0]  c1;
  logic        c2;
  logic [3:0]  u1, t1;
  // BCD add of at most 18 with decimal carry; a hundreds overflow saturates to 999
  always_comb begin
    add = (enemy_killed ? 5'(ENEMY_POINTS) : 5'd0) + (wall_destroyed ? 5'(WALL_POINTS) : 5'd0);
    us = {1'b0, score_bcd[3:0]} + add;
    c1 = us >= 5'd20 ? 2'd2 : us >= 5'd10 ? 2'd1 : 2'd0;
    u1 = 4'(us - 5'(c1) * 5'd10);
    ts = {1'b0, score_bcd[7:4]} + 5'(c1);
    c2 = ts >= 5'd10;
    t1 = 4'(c2 ? ts - 5'd10 : ts);
    hs = {1'b0, score_bcd[11:8]} + 5'(c2);
    score_sum = hs >= 5'd10 ? 12'h999 : {hs[3:0], t1, u1};
  end
  always_comb begin
    state_n = state;
    lives_n = lives;
    score_n = score_bcd;
    invuln_n = invuln_cnt;
    blink_n = blink_cnt;
    blink_q_n = player_blink;
    case (state)
      IDLE, GAME_OVER: if (start_game) begin
        state_n = PLAY;
        lives_n = 3'(INIT_LIVES);
        score_n = 12'h000;
      end
      PLAY: begin
        score_n = score_sum;
        if (player_hit) begin
          if (lives > 3'd1) begin
            state_n = INVULN;
            lives_n = lives - 3'd1;
            invuln_n = 8'(INVULN_FRAMES);
            blink_n = 4'd0;
            blink_q_n = 1'b0;
          end else begin
            state_n = GAME_OVER;
            lives_n = 3'd0;
          end
        end
      end
      INVULN: begin
        score_n = score_sum;
        if (startOfFrame) begin
          invuln_n = invuln_cnt - 8'd1;
          if (invuln_cnt == 8'd1) begin
            state_n = PLAY;
            blink_q_n = 1'b0;
          end else begin
            blink_n = blink_cnt == 4'(BLINK_FRAMES - 1) ? 4'd0 : blink_cnt + 4'd1;
            blink_q_n = blink_cnt == 4'(BLINK_FRAMES - 1) ? ~player_blink : player_blink;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      lives <= 3'd0;
      score_bcd <= 12'h000;
      invuln_cnt <= 8'd0;
      blink_cnt <= 4'd0;
      player_blink <= 1'b0;
    end else begin
      state <= state_n;
      lives <= lives_n;
      score_bcd <= score_n;
      invuln_cnt <= invuln_n;
      blink_cnt <= blink_n;
      player_blink <= blink_q_n;
    end
  end
  assign invulnerable = state == INVULN;
  assign game_active = state == PLAY || state == INVULN;
  assign game_over = state == GAME_OVER;
endmodule

// File: tb/tb_player_life_manager.sv
// tb_player_life_manager: directed sequence against a behavioural model via an expectation queue.
module tb_player_life_manager;
  logic clk = 1'b0;
  logic resetN, startOfFrame, start_game, player_hit, enemy_killed, wall_destroyed;
  logic [2:0] lives;
  logic [11:0] score_bcd;
  logic invulnerable, player_blink, game_active, game_over;
  int errors = 0, checks = 0;
  int m_st = 0, m_lives = 0, m_score = 0, m_f = 0;
  typedef struct {string tag; logic [18:0] v;} exp_t;
  exp_t q[$];
  player_life_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
    .player_hit(player_hit), .enemy_killed(enemy_killed), .wall_destroyed(wall_destroyed),
    .lives(lives), .score_bcd(score_bcd), .invulnerable(invulnerable),
    .player_blink(player_blink), .game_active(game_active), .game_over(game_over)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] bcd(int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction
  task automatic chk(string tag, logic [18:0] got, logic [18:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  // Model: m_f counts frames since the hit; blink is bit 0 of m_f/4 while invulnerable
  task automatic cyc(string tag, logic rn, logic sof, logic sg, logic ph, logic ek, logic wd);
    exp_t e;
    int pts;
    {resetN, startOfFrame, start_game, player_hit, enemy_killed, wall_destroyed} = {rn, sof, sg, ph, ek, wd};
    pts = (ek ? 5 : 0) + (wd ? 1 : 0);
    if (!rn) begin
      m_st = 0; m_lives = 0; m_score = 0; m_f = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (sg) begin m_st = 1; m_lives = 3; m_score = 0; end
    end else if (m_st == 1) begin
      m_score = (m_score + pts > 999) ? 999 : m_score + pts;
      if (ph) begin
        if (m_lives > 1) begin m_st = 2; m_lives--; m_f = 0; end
        else begin m_st = 3; m_lives = 0; end
      end
    end else begin
      m_score = (m_score + pts > 999) ? 999 : m_score + pts;
      if (sof) begin
        m_f++;
        if (m_f == 60) m_st = 1;
      end
    end
    e.tag = tag;
    e.v = {3'(m_lives), bcd(m_score), m_st == 2, m_st == 2 && ((m_f / 4) % 2 == 1), m_st == 1 || m_st == 2, m_st == 3};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk(e.tag, {lives, score_bcd, invulnerable, player_blink, game_active, game_over}, e.v);
  endtask
  task automatic frame(string tag);
    cyc(tag, 1, 1, 0, 0, 0, 0);
    cyc("idle", 1, 0, 0, 0, 0, 0);
  endtask
  task automatic frames(string tag, int n);
    for (int i = 0; i < n; i++) frame(tag);
  endtask
  initial begin
    cyc("reset", 0, 0, 0, 0, 0, 0);
    cyc("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_outs", {lives, score_bcd, invulnerable, player_blink, game_active, game_over}, 19'd0);
    cyc("start", 1, 0, 1, 0, 0, 0);
    chk("start_state", 19'({lives, score_bcd, game_active}), 19'({3'd3, 12'h000, 1'b1}));
    cyc("hit1", 1, 0, 0, 1, 0, 0);
    chk("hit1_state", 19'({lives, invulnerable}), 19'({3'd2, 1'b1}));
    for (int i = 1; i <= 60; i++) begin
      frame("invuln");
      if (i == 10) begin
        cyc("hit_ignored", 1, 0, 0, 1, 0, 0);
        chk("hit_ignored_lives", 19'(lives), 19'd2);
      end
      if (i < 60 && i % 4 == 0) chk("blink_phase", 19'(player_blink), 19'((i / 4) % 2));
    end
    chk("invuln_end", 19'({invulnerable, game_active}), 19'b01);
    repeat (15) cyc("score_ew", 1, 0, 0, 0, 1, 1);
    repeat (4) cyc("score_w", 1, 0, 0, 0, 0, 1);
    chk("score_094", 19'(score_bcd), 19'h094);
    cyc("score_carry", 1, 0, 0, 0, 1, 1);
    chk("score_100", 19'(score_bcd), 19'h100);
    repeat (149) cyc("score_ew", 1, 0, 0, 0, 1, 1);
    repeat (2) cyc("score_w", 1, 0, 0, 0, 0, 1);
    chk("score_996", 19'(score_bcd), 19'h996);
    cyc("score_sat", 1, 0, 0, 0, 1, 1);
    chk("score_999", 19'(score_bcd), 19'h999);
    cyc("score_sat2", 1, 0, 0, 0, 1, 0);
    chk("score_999_hold", 19'(score_bcd), 19'h999);
    cyc("hit2", 1, 0, 0, 1, 0, 0);
    frames("invuln2", 3);
    cyc("reset_mid", 0, 0, 0, 0, 0, 0);
    chk("reset_mid_outs", {lives, score_bcd, invulnerable, player_blink, game_active, game_over}, 19'd0);
    cyc("restart", 1, 0, 1, 0, 0, 0);
    repeat (2) cyc("score_w", 1, 0, 0, 0, 0, 1);
    cyc("start_in_play", 1, 0, 1, 0, 0, 0);
    chk("start_ignored", 19'({lives, score_bcd, game_active}), 19'({3'd3, 12'h002, 1'b1}));
    cyc("hitA", 1, 0, 0, 1, 0, 0);
    frames("invulnA", 60);
    cyc("hitB_immediate", 1, 0, 0, 1, 0, 0);
    chk("hitB_lives", 19'({lives, invulnerable}), 19'({3'd1, 1'b1}));
    frames("invulnB", 60);
    repeat (8) cyc("score_w", 1, 0, 0, 0, 0, 1);
    chk("score_010", 19'(score_bcd), 19'h010);
    cyc("final_hit_kill", 1, 0, 0, 1, 1, 0);
    chk("final_hit", {lives, score_bcd, invulnerable, player_blink, game_active, game_over},
        {3'd0, 12'h015, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (3) cyc("kill_in_over", 1, 0, 0, 0, 1, 1);
    chk("over_frozen", 19'({lives, score_bcd, game_over}), 19'({3'd0, 12'h015, 1'b1}));
    cyc("restart_over", 1, 0, 1, 0, 0, 0);
    chk("restart_over_state", 19'({lives, score_bcd, game_active, game_over}), 19'({3'd3, 12'h000, 1'b1, 1'b0}));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
